fu_br_queue: RTL and testbench
==============================

Name: fu_br_queue

Overview:
- Parametrised branch functional unit. Accepts up to DEPTH dispatched branch/jump ops and holds them in an in-order buffer.
- Captures missing operands from the CDB and resolves the oldest op once both of its operands are ready.
- Resolution covers condition, target, link value and mispredict against the fetch prediction.
- Sits between the RS issue port and the CDB/ROB completion path.
- Differs from the single-slot unit: multi-entry, tag-based operand wakeup, valid/ready output handshake, built-in mispredict detection.

Parameters:
- XLEN, 32, datapath width.
- DEPTH, 4, in-flight branch entries (power of 2, >=2).
- TAG_W, 6, physical/ROB tag width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- squash  in  1  pipeline flush; kills all entries and the output stage
- in_valid  in  1  dispatch request
- in_ready  out  1  entry available (count != DEPTH)
- in_pc  in  XLEN  branch PC
- in_inst  in  32  raw instruction (immediates, funct3)
- in_cond  in  1  conditional branch
- in_uncond  in  1  JAL/JALR
- in_jalr  in  1  target base is rs1, not PC
- in_pred_taken  in  1  fetch prediction
- in_pred_target  in  XLEN  predicted target
- in_rs1_val / in_rs2_val  in  XLEN  operand values
- in_rs1_rdy / in_rs2_rdy  in  1  operand valid
- in_rs1_tag / in_rs2_tag  in  TAG_W  producer tags
- in_dest_tag  in  TAG_W  destination tag
- cdb_valid  in  1  broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_value  in  XLEN  broadcast value
- out_valid  out  1  resolved result valid
- out_ready  in  1  consumer accepts
- out_take  out  1  branch taken
- out_target  out  XLEN  resolved next PC when taken
- out_link  out  XLEN  PC+4
- out_mispredict  out  1  prediction wrong
- out_dest_tag  out  TAG_W  destination tag
- occupancy  out  $clog2(DEPTH)+1  valid entries

Behaviour:
- Reset/squash (same cycle, priority over all else): head=tail=count=0, all entry valids cleared, out_valid=0, other out_* registers 0, occupancy=0, in_ready=1 from the next cycle.
- Enqueue: in_valid && in_ready && !squash writes the tail entry and increments tail modulo DEPTH.
  - If cdb_valid and cdb_tag equals a not-ready incoming operand's tag in that same cycle, the entry stores cdb_value as ready.
- Wakeup: each cycle every valid entry with a not-ready operand whose tag == cdb_tag while cdb_valid captures cdb_value and sets rdy. Both operands may wake in the same cycle.
- Resolve: the head resolves when its valid && rs1_rdy && rs2_rdy && (!out_valid || out_ready).
  - Output registers load at the next edge: latency 1 cycle from the head becoming ready.
  - Head advances and count decrements.
  - Enqueue and resolve in the same cycle leave count unchanged.
- Condition by funct3: BEQ/BNE/BLT/BGE signed, BLTU/BGEU unsigned; other funct3 gives cond=0.
- take = in_uncond || (in_cond && cond).
- Target:
  - JALR: (rs1 + signext Iimm) & ~1.
  - JAL: PC + signext Jimm.
  - Branch: PC + signext Bimm.
- All arithmetic is modulo 2^XLEN.
- out_link = PC + 4.
- out_mispredict = (take != pred_taken) || (take && target != pred_target).
- Output handshake:
  - out_* hold stable while out_valid && !out_ready.
  - Transfer occurs on out_valid && out_ready.
  - Back-to-back transfers every cycle are allowed when the head is ready.
- Full: in_ready=0 at count==DEPTH, even if a resolve occurs that cycle.
- Empty: no resolve; out_valid drops after the last transfer.
- Pointer wrap-around: head/tail are $clog2(DEPTH) bits and wrap naturally.

Optional Feature:
- FU_BR_SELF_FLUSH_EN
- Defined: when an entry resolving with mispredict=1 is loaded into the output stage, all remaining (younger) entries are invalidated the same edge and tail is set to head+1 position after the resolved entry. count becomes 0 and in_ready stays 0 until out_valid && out_ready for that result.
- Undefined: younger entries remain until external squash.

Decomposition:
- Shared package: BR_FUNCT3 enum (BEQ..BGEU), immediate-extract functions, and a BR_ENTRY struct {valid, pc, inst, cond, uncond, jalr, pred_taken, pred_target, rs1/rs2 val/rdy/tag, dest_tag}.
- One natural sub-module: br_resolve, purely combinational; takes the head entry and produces take/target/link/mispredict.

Test Plan:
- Reset, then enqueue BEQ pc=0x100 rs1=5 rs2=5 both ready, Bimm=+16, pred_taken=0 -> one cycle later out_valid=1, out_take=1, out_target=0x110, out_link=0x104, out_mispredict=1.
- Enqueue BLT with rs1 tag 7 not ready, rs2=3; after 3 idle cycles drive cdb tag=7 value=0xFFFFFFFF -> resolves next cycle, take=1 (signed -1<3). Repeat as BLTU -> take=0.
- Fill DEPTH=4 with ready ops while out_ready=0 -> first result held stable; in_ready=0 at count=4 (one already in output, buffer holds 3 plus 1 enqueued). Raise out_ready -> 4 results in 4 consecutive cycles, in order.
- JALR rs1=0x2003 Iimm=+4, pred_target=0x2006, pred_taken=1 -> target=0x2006, mispredict=0. Same with pred_target=0x2008 -> mispredict=1.
- Squash asserted concurrently with in_valid and cdb_valid, 2 entries pending -> next cycle occupancy=0, out_valid=0, new entry not enqueued.
- With FU_BR_SELF_FLUSH_EN: 3 entries, head mispredicts -> occupancy=0 after resolve, younger results never appear.

Source files
------------

// File: rtl/fu_br_queue_pkg.sv
// Shared definitions for the branch queue: branch funct3 encodings and
// RV32 immediate extraction helpers (results are sign-extended to 32 bits).
package fu_br_queue_pkg;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_funct3_e;

  function automatic logic [31:0] imm_i(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fu_br_queue_resolve.sv
// Combinational branch resolution for the queue head: condition, taken,
// next-PC target, link value and mispredict against the fetch prediction.
module fu_br_queue_resolve
  import fu_br_queue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [31:0]     i_inst,
  input  logic            i_cond,
  input  logic            i_uncond,
  input  logic            i_jalr,
  input  logic            i_pred_taken,
  input  logic [XLEN-1:0] i_pred_target,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_take,
  output logic [XLEN-1:0] o_target,
  output logic [XLEN-1:0] o_link,
  output logic            o_mispredict
);

  logic            w_cond;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_sum;

  always_comb begin
    w_cond = 1'b0;
    case (br_funct3_e'(i_inst[14:12]))
      BR_BEQ:  w_cond = (i_rs1 == i_rs2);
      BR_BNE:  w_cond = (i_rs1 != i_rs2);
      BR_BLT:  w_cond = ($signed(i_rs1) <  $signed(i_rs2));
      BR_BGE:  w_cond = ($signed(i_rs1) >= $signed(i_rs2));
      BR_BLTU: w_cond = (i_rs1 <  i_rs2);
      BR_BGEU: w_cond = (i_rs1 >= i_rs2);
      default: w_cond = 1'b0;
    endcase
  end

  // JALR takes I-imm off rs1; JAL uses J-imm and branches B-imm off the PC.
  always_comb begin
    w_base = i_jalr ? i_rs1 : i_pc;
    if (i_jalr)        w_imm = XLEN'($signed(imm_i(i_inst)));
    else if (i_uncond) w_imm = XLEN'($signed(imm_j(i_inst)));
    else               w_imm = XLEN'($signed(imm_b(i_inst)));
  end

  assign w_sum        = w_base + w_imm;
  assign o_target     = i_jalr ? (w_sum & {{(XLEN-1){1'b1}}, 1'b0}) : w_sum;
  assign o_take       = i_uncond || (i_cond && w_cond);
  assign o_link       = i_pc + XLEN'(4);
  assign o_mispredict = (o_take != i_pred_taken) ||
                        (o_take && (o_target != i_pred_target));

endmodule

// File: rtl/fu_br_queue.sv
// Multi-entry in-order branch unit with CDB operand wakeup and a registered
// valid/ready result stage. Optional FU_BR_SELF_FLUSH_EN drops younger ops on mispredict.
module fu_br_queue
  import fu_br_queue_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     squash,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [31:0]              in_inst,
  input  logic                     in_cond,
  input  logic                     in_uncond,
  input  logic                     in_jalr,
  input  logic                     in_pred_taken,
  input  logic [XLEN-1:0]          in_pred_target,
  input  logic [XLEN-1:0]          in_rs1_val,
  input  logic [XLEN-1:0]          in_rs2_val,
  input  logic                     in_rs1_rdy,
  input  logic                     in_rs2_rdy,
  input  logic [TAG_W-1:0]         in_rs1_tag,
  input  logic [TAG_W-1:0]         in_rs2_tag,
  input  logic [TAG_W-1:0]         in_dest_tag,
  input  logic                     cdb_valid,
  input  logic [TAG_W-1:0]         cdb_tag,
  input  logic [XLEN-1:0]          cdb_value,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_take,
  output logic [XLEN-1:0]          out_target,
  output logic [XLEN-1:0]          out_link,
  output logic                     out_mispredict,
  output logic [TAG_W-1:0]         out_dest_tag,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Output handshake: a result moves on any cycle where out_valid && out_ready;
  // while out_valid && !out_ready every out_* register holds its value.
  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [31:0]       inst;
    logic              cond;
    logic              uncond;
    logic              jalr;
    logic              pred_taken;
    logic [XLEN-1:0]   pred_target;
    logic [XLEN-1:0]   rs1_val;
    logic              rs1_rdy;
    logic [TAG_W-1:0]  rs1_tag;
    logic [XLEN-1:0]   rs2_val;
    logic              rs2_rdy;
    logic [TAG_W-1:0]  rs2_tag;
    logic [TAG_W-1:0]  dest_tag;
  } br_entry_t;

  br_entry_t        r_q [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_out_valid;
  logic             r_out_take;
  logic [XLEN-1:0]  r_out_target;
  logic [XLEN-1:0]  r_out_link;
  logic             r_out_mispredict;
  logic [TAG_W-1:0] r_out_dest_tag;
  logic             r_flush_hold;

  br_entry_t        w_head;
  br_entry_t        w_new;
  logic             w_enq;
  logic             w_res;
  logic             w_xfer;
  logic             w_take;
  logic             w_mis;
  logic [XLEN-1:0]  w_target;
  logic [XLEN-1:0]  w_link;

  assign w_head   = r_q[r_head];
  assign in_ready = (r_count != CNT_W'(DEPTH)) && !r_flush_hold;
  assign w_enq    = in_valid && in_ready && !squash;
  assign w_xfer   = r_out_valid && out_ready;
  assign w_res    = w_head.valid && w_head.rs1_rdy && w_head.rs2_rdy &&
                    (!r_out_valid || out_ready);

  // Incoming entry, with same-cycle CDB capture for operands still pending.
  always_comb begin
    w_new             = '0;
    w_new.valid       = 1'b1;
    w_new.pc          = in_pc;
    w_new.inst        = in_inst;
    w_new.cond        = in_cond;
    w_new.uncond      = in_uncond;
    w_new.jalr        = in_jalr;
    w_new.pred_taken  = in_pred_taken;
    w_new.pred_target = in_pred_target;
    w_new.rs1_val     = in_rs1_val;
    w_new.rs1_rdy     = in_rs1_rdy;
    w_new.rs1_tag     = in_rs1_tag;
    w_new.rs2_val     = in_rs2_val;
    w_new.rs2_rdy     = in_rs2_rdy;
    w_new.rs2_tag     = in_rs2_tag;
    w_new.dest_tag    = in_dest_tag;
    if (!in_rs1_rdy && cdb_valid && (cdb_tag == in_rs1_tag)) begin
      w_new.rs1_rdy = 1'b1;
      w_new.rs1_val = cdb_value;
    end
    if (!in_rs2_rdy && cdb_valid && (cdb_tag == in_rs2_tag)) begin
      w_new.rs2_rdy = 1'b1;
      w_new.rs2_val = cdb_value;
    end
  end

  fu_br_queue_resolve #(.XLEN(XLEN)) u_resolve (
    .i_pc          (w_head.pc),
    .i_inst        (w_head.inst),
    .i_cond        (w_head.cond),
    .i_uncond      (w_head.uncond),
    .i_jalr        (w_head.jalr),
    .i_pred_taken  (w_head.pred_taken),
    .i_pred_target (w_head.pred_target),
    .i_rs1         (w_head.rs1_val),
    .i_rs2         (w_head.rs2_val),
    .o_take        (w_take),
    .o_target      (w_target),
    .o_link        (w_link),
    .o_mispredict  (w_mis)
  );

  always_ff @(posedge clock) begin
    if (reset || squash) begin
      r_head           <= '0;
      r_tail           <= '0;
      r_count          <= '0;
      r_out_valid      <= 1'b0;
      r_out_take       <= 1'b0;
      r_out_target     <= '0;
      r_out_link       <= '0;
      r_out_mispredict <= 1'b0;
      r_out_dest_tag   <= '0;
      r_flush_hold     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_q[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_q[i].valid && cdb_valid) begin
          if (!r_q[i].rs1_rdy && (r_q[i].rs1_tag == cdb_tag)) begin
            r_q[i].rs1_rdy <= 1'b1;
            r_q[i].rs1_val <= cdb_value;
          end
          if (!r_q[i].rs2_rdy && (r_q[i].rs2_tag == cdb_tag)) begin
            r_q[i].rs2_rdy <= 1'b1;
            r_q[i].rs2_val <= cdb_value;
          end
        end
      end

      if (w_enq) begin
        r_q[r_tail] <= w_new;
        r_tail      <= r_tail + PTR_W'(1);
      end

      if (w_res) begin
        r_q[r_head].valid <= 1'b0;
        r_head            <= r_head + PTR_W'(1);
        r_out_valid       <= 1'b1;
        r_out_take        <= w_take;
        r_out_target      <= w_target;
        r_out_link        <= w_link;
        r_out_mispredict  <= w_mis;
        r_out_dest_tag    <= w_head.dest_tag;
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
      end

      case ({w_enq, w_res})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

`ifdef FU_BR_SELF_FLUSH_EN
      if (w_xfer) r_flush_hold <= 1'b0;
      // Mispredict kills every younger op, including one enqueued this cycle.
      if (w_res && w_mis) begin
        for (int i = 0; i < DEPTH; i++) r_q[i].valid <= 1'b0;
        r_tail       <= r_head + PTR_W'(1);
        r_count      <= '0;
        r_flush_hold <= 1'b1;
      end
`else
      r_flush_hold <= 1'b0;
`endif
    end
  end

  assign out_valid      = r_out_valid;
  assign out_take       = r_out_take;
  assign out_target     = r_out_target;
  assign out_link       = r_out_link;
  assign out_mispredict = r_out_mispredict;
  assign out_dest_tag   = r_out_dest_tag;
  assign occupancy      = r_count;

endmodule

// File: tb/tb_fu_br_queue.sv
// Directed bench for fu_br_queue: results are predicted from the intended
// immediates/operands and checked in order as they leave the output stage.
module tb_fu_br_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int TAG_W = 6;
  localparam int RW    = 1 + XLEN + XLEN + 1 + TAG_W;

  logic             clock = 1'b0;
  logic             reset, squash, in_valid, in_ready;
  logic [XLEN-1:0]  in_pc, in_pred_target, in_rs1_val, in_rs2_val;
  logic [31:0]      in_inst;
  logic             in_cond, in_uncond, in_jalr, in_pred_taken;
  logic             in_rs1_rdy, in_rs2_rdy;
  logic [TAG_W-1:0] in_rs1_tag, in_rs2_tag, in_dest_tag;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_value;
  logic             out_valid, out_ready, out_take, out_mispredict;
  logic [XLEN-1:0]  out_target, out_link;
  logic [TAG_W-1:0] out_dest_tag;
  logic [2:0]       occupancy;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] mon_e, mon_o;
  int n_tests = 0;
  int n_fail  = 0;

  fu_br_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .in_cond(in_cond), .in_uncond(in_uncond), .in_jalr(in_jalr),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .in_rs1_rdy(in_rs1_rdy), .in_rs2_rdy(in_rs2_rdy),
    .in_rs1_tag(in_rs1_tag), .in_rs2_tag(in_rs2_tag), .in_dest_tag(in_dest_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_take(out_take),
    .out_target(out_target), .out_link(out_link), .out_mispredict(out_mispredict),
    .out_dest_tag(out_dest_tag), .occupancy(occupancy)
  );

  // Clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // kind: 0 = conditional branch, 1 = JAL, 2 = JALR
  function automatic logic [31:0] enc(input int kind, input logic [2:0] f3, input logic [31:0] imm);
    case (kind)
      1:       return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'h6F};
      2:       return {imm[11:0], 5'd1, 3'b000, 5'd1, 7'h67};
      default: return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'h63};
    endcase
  endfunction

  function automatic logic [RW-1:0] model(input logic [31:0] pc, input int kind, input logic [2:0] f3,
                                          input logic [31:0] imm, input logic pt, input logic [31:0] ptgt,
                                          input logic [31:0] rs1, input logic [31:0] rs2,
                                          input logic [TAG_W-1:0] dest);
    logic c, tk, mis;
    logic [31:0] tgt;
    case (f3)
      3'd0:    c = (rs1 == rs2);
      3'd1:    c = (rs1 != rs2);
      3'd4:    c = ($signed(rs1) < $signed(rs2));
      3'd5:    c = !($signed(rs1) < $signed(rs2));
      3'd6:    c = (rs1 < rs2);
      3'd7:    c = !(rs1 < rs2);
      default: c = 1'b0;
    endcase
    tk  = (kind != 0) ? 1'b1 : c;
    tgt = (kind == 2) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
    mis = (tk != pt) || (tk && (tgt != ptgt));
    return {tk, tgt, pc + 32'd4, mis, dest};
  endfunction

  // Driver: a not-ready operand is driven inverted so only the CDB value can be used.
  task automatic enq(input logic [31:0] pc, input int kind, input logic [2:0] f3, input logic [31:0] imm,
                     input logic pt, input logic [31:0] ptgt,
                     input logic [31:0] rs1, input logic r1r, input logic [TAG_W-1:0] t1,
                     input logic [31:0] rs2, input logic r2r, input logic [TAG_W-1:0] t2,
                     input logic [TAG_W-1:0] dest, input bit push);
    in_valid       = 1'b1;
    in_pc          = pc;
    in_inst        = enc(kind, (kind == 0) ? f3 : 3'd0, imm);
    in_cond        = (kind == 0);
    in_uncond      = (kind != 0);
    in_jalr        = (kind == 2);
    in_pred_taken  = pt;
    in_pred_target = ptgt;
    in_rs1_val     = r1r ? rs1 : ~rs1;
    in_rs1_rdy     = r1r;
    in_rs1_tag     = t1;
    in_rs2_val     = r2r ? rs2 : ~rs2;
    in_rs2_rdy     = r2r;
    in_rs2_tag     = t2;
    in_dest_tag    = dest;
    if (push) exp_q.push_back(model(pc, kind, f3, imm, pt, ptgt, rs1, rs2, dest));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic cdb(input logic [TAG_W-1:0] tag, input logic [31:0] val);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_value = val;
    tick();
    cdb_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < budget) begin
      tick();
      k++;
    end
    n_tests++;
    assert (exp_q.size() == 0 && !out_valid) else begin
      n_fail++;
      $error("FAIL %s: got %0d results outstanding, out_valid=%0b expected 0", tag, exp_q.size(), out_valid);
    end
  endtask

  // Scoreboard: compare every transfer against the oldest expected result.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      n_tests++;
      mon_o = {out_take, out_target, out_link, out_mispredict, out_dest_tag};
      if (exp_q.size() == 0) begin
        n_fail++;
        $error("FAIL unexpected_out: got %0h expected no result", mon_o);
      end else begin
        mon_e = exp_q.pop_front();
        assert (mon_o === mon_e) else begin
          n_fail++;
          $error("FAIL out_result: got %0h expected %0h", mon_o, mon_e);
        end
      end
    end
  end

  initial begin
    logic [31:0] r1, r2, bimm, pc;
    logic [12:0] rb;
    logic        pt;

    reset = 1'b1; squash = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_inst = '0; in_cond = 0; in_uncond = 0; in_jalr = 0;
    in_pred_taken = 0; in_pred_target = '0; in_rs1_val = '0; in_rs2_val = '0;
    in_rs1_rdy = 0; in_rs2_rdy = 0; in_rs1_tag = '0; in_rs2_tag = '0; in_dest_tag = '0;
    cdb_valid = 0; cdb_tag = '0; cdb_value = '0;
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 1'b0;

    // BEQ taken, predicted not-taken
    enq(32'h100, 0, 3'd0, 32'd16, 0, 32'h0, 32'd5, 1, 0, 32'd5, 1, 0, 6'd1, 1);
    check("beq_lat0_valid", out_valid, 0);
    check("beq_occupancy", occupancy, 1);
    tick();
    check("beq_valid", out_valid, 1);
    check("beq_take", out_take, 1);
    check("beq_target", out_target, 32'h110);
    check("beq_link", out_link, 32'h104);
    check("beq_mispredict", out_mispredict, 1);
    tick();
    check("beq_drained_valid", out_valid, 0);
    check("beq_drained_occ", occupancy, 0);

    // BLT waiting on rs1 tag 7, then BLTU with the same operands
    enq(32'h200, 0, 3'd4, 32'hFFFF_FFF8, 0, 32'h0, 32'hFFFF_FFFF, 0, 6'd7, 32'd3, 1, 0, 6'd2, 1);
    tick(); tick(); tick();
    check("blt_blocked", out_valid, 0);
    cdb(6'd7, 32'hFFFF_FFFF);
    check("blt_wake_lat", out_valid, 0);
    tick();
    check("blt_valid", out_valid, 1);
    check("blt_take", out_take, 1);
    wait_drain("blt_drain", 20);
    enq(32'h200, 0, 3'd6, 32'hFFFF_FFF8, 0, 32'h0, 32'hFFFF_FFFF, 0, 6'd7, 32'd3, 1, 0, 6'd3, 1);
    tick(); tick(); tick();
    cdb(6'd7, 32'hFFFF_FFFF);
    tick();
    check("bltu_valid", out_valid, 1);
    check("bltu_take", out_take, 0);
    wait_drain("bltu_drain", 20);

    // CDB bypass on the enqueue cycle
    cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_value = 32'd2;
    enq(32'h300, 0, 3'd1, 32'h20, 1, 32'h320, 32'd1, 1, 0, 32'd2, 0, 6'd9, 6'd4, 1);
    cdb_valid = 1'b0;
    tick();
    check("bypass_valid", out_valid, 1);
    check("bypass_take", out_take, 1);
    wait_drain("bypass_drain", 20);

    // Both operands wake on one broadcast
    enq(32'h400, 0, 3'd0, 32'd8, 1, 32'h408, 32'h55, 0, 6'd10, 32'h55, 0, 6'd10, 6'd5, 1);
    tick();
    cdb(6'd10, 32'h55);
    wait_drain("dual_wake_drain", 20);

    // Fill with the output stage stalled, then stream out back-to-back
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      enq(32'h500 + 32'(16 * i), 0, 3'd0, 32'd12, 1, 32'h50C + 32'(16 * i),
          32'(i), 1, 0, 32'(i), 1, 0, 6'(16 + i), 1);
    check("full_in_ready", in_ready, 0);
    check("full_occupancy", occupancy, 4);
    check("full_out_valid", out_valid, 1);
    check("full_dest", out_dest_tag, 16);
    tick();
    check("hold_dest", out_dest_tag, 16);
    check("hold_target", out_target, 32'h50C);
    out_ready = 1'b1;
    check("full_resolve_in_ready", in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stream_valid", out_valid, 1);
    end
    tick();
    check("stream_end_valid", out_valid, 0);
    check("stream_end_occ", occupancy, 0);

    // JALR / JAL targets
    enq(32'h1000, 2, 3'd0, 32'd4, 1, 32'h2006, 32'h2003, 1, 0, 32'd0, 1, 0, 6'd6, 1);
    tick();
    check("jalr_target", out_target, 32'h2006);
    check("jalr_mis", out_mispredict, 0);
    check("jalr_link", out_link, 32'h1004);
    wait_drain("jalr_drain", 20);
    enq(32'h1000, 2, 3'd0, 32'd4, 1, 32'h2008, 32'h2003, 1, 0, 32'd0, 1, 0, 6'd7, 1);
    tick();
    check("jalr_mis2", out_mispredict, 1);
    wait_drain("jalr2_drain", 20);
    enq(32'h3000, 1, 3'd0, 32'hFFFF_F800, 1, 32'h2800, 32'd0, 1, 0, 32'd0, 1, 0, 6'd8, 1);
    tick();
    check("jal_target", out_target, 32'h2800);
    wait_drain("jal_drain", 20);

    // Random operands across every funct3, including the undefined ones
    for (int i = 0; i < 16; i++) begin
      r1   = $urandom;
      r2   = (i < 8) ? r1 : ((i % 3 == 0) ? ~r1 : $urandom);
      rb   = 13'($urandom_range(0, 8191)) & 13'h1FFE;
      bimm = {{19{rb[12]}}, rb};
      pc   = 32'($urandom_range(0, 65535)) << 2;
      pt   = 1'($urandom_range(0, 1));
      enq(pc, 0, 3'(i % 8), bimm, pt, ($urandom_range(0, 1) != 0) ? pc + bimm : 32'h4,
          r1, 1, 0, r2, 1, 0, 6'(32 + i), 1);
      wait_drain("rand_drain", 20);
    end

    // Squash together with enqueue and CDB, two entries pending
    out_ready = 1'b0;
    enq(32'h600, 0, 3'd0, 32'd8, 1, 32'h608, 32'd1, 1, 0, 32'd1, 1, 0, 6'd40, 0);
    enq(32'h610, 0, 3'd0, 32'd8, 1, 32'h618, 32'd2, 0, 6'd20, 32'd2, 1, 0, 6'd41, 0);
    enq(32'h620, 0, 3'd0, 32'd8, 1, 32'h628, 32'd3, 0, 6'd20, 32'd3, 1, 0, 6'd42, 0);
    check("pre_squash_occ", occupancy, 2);
    check("pre_squash_valid", out_valid, 1);
    squash = 1'b1; cdb_valid = 1'b1; cdb_tag = 6'd20; cdb_value = 32'd2;
    enq(32'h630, 0, 3'd0, 32'd8, 1, 32'h638, 32'd4, 1, 0, 32'd4, 1, 0, 6'd43, 0);
    squash = 1'b0; cdb_valid = 1'b0;
    check("squash_occ", occupancy, 0);
    check("squash_valid", out_valid, 0);
    check("squash_in_ready", in_ready, 1);
    out_ready = 1'b1;
    tick(); tick(); tick();
    check("post_squash_valid", out_valid, 0);
    check("post_squash_occ", occupancy, 0);

    // Head mispredicts with two younger ops behind it
    out_ready = 1'b0;
    enq(32'h700, 0, 3'd0, 32'd8, 0, 32'h0, 32'd7, 0, 6'd30, 32'd7, 1, 0, 6'd50, 1);
`ifdef FU_BR_SELF_FLUSH_EN
    enq(32'h710, 0, 3'd0, 32'd8, 1, 32'h718, 32'd1, 1, 0, 32'd1, 1, 0, 6'd51, 0);
    enq(32'h720, 0, 3'd0, 32'd8, 1, 32'h728, 32'd1, 1, 0, 32'd1, 1, 0, 6'd52, 0);
`else
    enq(32'h710, 0, 3'd0, 32'd8, 1, 32'h718, 32'd1, 1, 0, 32'd1, 1, 0, 6'd51, 1);
    enq(32'h720, 0, 3'd0, 32'd8, 1, 32'h728, 32'd1, 1, 0, 32'd1, 1, 0, 6'd52, 1);
`endif
    check("mis_occ3", occupancy, 3);
    cdb(6'd30, 32'd7);
    check("mis_wake_lat", out_valid, 0);
    tick();
    check("mis_out_valid", out_valid, 1);
    check("mis_out_dest", out_dest_tag, 50);
`ifdef FU_BR_SELF_FLUSH_EN
    check("flush_occ", occupancy, 0);
    check("flush_in_ready", in_ready, 0);
`else
    check("noflush_occ", occupancy, 2);
    check("noflush_in_ready", in_ready, 1);
`endif
    out_ready = 1'b1;
    wait_drain("mis_drain", 20);
    tick(); tick();
    check("mis_end_valid", out_valid, 0);
    check("mis_end_occ", occupancy, 0);
    check("mis_end_in_ready", in_ready, 1);

    wait_drain("final_drain", 20);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
